// File: rtl/mod_counter_nb.sv
// Parametrised up/down modulus counter with parallel load, combinational terminal
// count and a registered carry/borrow pulse; cout of one stage feeds en of the next.
module mod_counter_nb #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             cout,
    output logic             tc
);

    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("mod_counter_nb: WIDTH must be 1..16");
        end
        if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
            $error("mod_counter_nb: MODULUS must be 2..2**WIDTH");
        end
    endgenerate

    localparam int unsigned    LAST_INT = MODULUS - 1;
    localparam logic [WIDTH:0] LAST     = LAST_INT[WIDTH:0];
    localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             cout_q, cout_d;
    logic [WIDTH:0]   ext_q;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;

    // One extra bit keeps MODULUS == 2**WIDTH from aliasing: the increment is
    // range-checked before truncation and a borrow out of zero sets the top bit.
    always_comb begin
        ext_q   = {1'b0, count_q};
        inc     = ext_q + ONE;
        dec     = ext_q - ONE;
        count_d = count_q;
        cout_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            if ({1'b0, load_val} > LAST) begin
                count_d = LAST[WIDTH-1:0];
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (up) begin
                if (inc > LAST) begin
                    cout_d  = 1'b1;
                    count_d = SATURATE ? count_q : '0;
                end else begin
                    count_d = inc[WIDTH-1:0];
                end
            end else begin
                if (dec[WIDTH]) begin
                    cout_d  = 1'b1;
                    count_d = SATURATE ? count_q : LAST[WIDTH-1:0];
                end else begin
                    count_d = dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cout_q  <= cout_d;
        end
    end

    assign count = count_q;
    assign cout  = cout_q;
    assign tc    = up ? (count_q == LAST[WIDTH-1:0]) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter_nb.sv
// Scoreboarded random/directed bench for mod_counter_nb across wrap, decade and
// saturating configurations driven by one shared stimulus stream.
module tb_mod_counter_nb;

    localparam int NI = 3;

    typedef struct packed {
        logic [NI-1:0][3:0] cnt;
        logic [NI-1:0]      co;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en, up;
    logic [3:0] load_val;
    logic [3:0] cnt_w [NI];
    logic       cout_w [NI];
    logic       tc_w [NI];

    int   ncmp = 0;
    int   nerr = 0;
    int   mcnt [NI];
    bit   running = 1'b0;
    exp_t sbq [$];

    always #5 clk = ~clk;

    mod_counter_nb #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_w[0]), .cout(cout_w[0]), .tc(tc_w[0]));
    mod_counter_nb #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dec10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_w[1]), .cout(cout_w[1]), .tc(tc_w[1]));
    mod_counter_nb #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_sat16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_w[2]), .cout(cout_w[2]), .tc(tc_w[2]));

    function automatic int mod_of(input int i);
        return (i == 1) ? 10 : 16;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 2);
    endfunction

    // Behavioural reference: next count and overflow flag from the counting rules.
    function automatic void model(input int i, input bit c_clr, input bit c_load,
                                  input int lv, input bit c_en, input bit c_up,
                                  output int n, output bit co);
        int m;
        int c;
        m  = mod_of(i);
        c  = mcnt[i];
        n  = c;
        co = 1'b0;
        if (c_clr) n = 0;
        else if (c_load) n = (lv < m) ? lv : m - 1;
        else if (c_en) begin
            if (c_up) begin
                if (c + 1 >= m) begin co = 1'b1; n = sat_of(i) ? c : 0; end
                else n = c + 1;
            end else begin
                if (c - 1 < 0) begin co = 1'b1; n = sat_of(i) ? c : m - 1; end
                else n = c - 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp_v);
        ncmp++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", nm, i, act, exp_v, $time);
        end
    endtask

    task automatic step(input bit c_clr, input bit c_load, input logic [3:0] lv,
                        input bit c_en, input bit c_up, input bit do_rst);
        exp_t e;
        int   n;
        bit   co;
        @(negedge clk);
        if (do_rst) begin
            rst_n = 1'b0;
            #2;
            for (int i = 0; i < NI; i++) begin
                chk("async_rst_count", i, int'(cnt_w[i]), 0);
                chk("async_rst_cout", i, int'(cout_w[i]), 0);
                mcnt[i] = 0;
            end
            rst_n = 1'b1;
        end
        clr      = c_clr;
        load     = c_load;
        load_val = lv;
        en       = c_en;
        up       = c_up;
        e        = '0;
        for (int i = 0; i < NI; i++) begin
            model(i, c_clr, c_load, int'(lv), c_en, c_up, n, co);
            mcnt[i]  = n;
            e.cnt[i] = n[3:0];
            e.co[i]  = co;
        end
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        int   tce;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (sbq.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL scoreboard_empty: got 0 entries, expected 1");
                end else begin
                    e = sbq.pop_front();
                    for (int i = 0; i < NI; i++) begin
                        tce = up ? int'(int'(e.cnt[i]) == mod_of(i) - 1) : int'(e.cnt[i] == 4'd0);
                        chk("count", i, int'(cnt_w[i]), int'(e.cnt[i]));
                        chk("cout", i, int'(cout_w[i]), int'(e.co[i]));
                        chk("tc", i, int'(tc_w[i]), tce);
                    end
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up = 1'b1;
        for (int i = 0; i < NI; i++) mcnt[i] = 0;
        #3;
        for (int i = 0; i < NI; i++) begin
            chk("reset_count", i, int'(cnt_w[i]), 0);
            chk("reset_cout", i, int'(cout_w[i]), 0);
            chk("reset_tc_up", i, int'(tc_w[i]), 0);
        end
        up = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk("reset_tc_down", i, int'(tc_w[i]), 1);
        up = 1'b1;
        #3 rst_n = 1'b1;
        running = 1'b1;

        step(0, 0, 4'd0, 0, 1, 0);
        step(0, 0, 4'd0, 0, 1, 0);
        for (int k = 0; k < 16; k++) step(0, 0, 4'd0, 1, 1, 0);
        step(0, 1, 4'd0, 0, 1, 0);
        for (int k = 0; k < 11; k++) step(0, 0, 4'd0, 1, 0, 0);
        step(0, 1, 4'b1100, 0, 0, 0);
        step(0, 1, 4'd5, 0, 1, 0);
        step(1, 1, 4'd9, 1, 1, 0);
        step(0, 1, 4'd7, 1, 1, 0);
        step(0, 0, 4'd0, 0, 1, 0);
        step(0, 1, 4'd15, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 4'd0, 1, 1, 0);
        step(0, 0, 4'd0, 1, 0, 0);
        step(0, 1, 4'd10, 0, 1, 0);
        step(0, 0, 4'd0, 1, 1, 0);
        step(0, 0, 4'd0, 1, 1, 1);
        step(0, 0, 4'd0, 1, 1, 0);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 4'($urandom_range(15)), ($urandom_range(3) != 0),
                 ($urandom_range(5) != 0) ? up : ~up, ($urandom_range(49) == 0));
        end

        @(posedge clk);
        #3;
        running = 1'b0;
        ncmp++;
        if (sbq.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
